// File: rtl/ora_fail_counter_bank.sv
// Session-timed, saturating multi-channel fail counter bank for the LBIST ORA stage.
// Counts per-channel mismatch strobes over a fixed-length session, then holds and grades them.
module ora_fail_counter_bank #(
    parameter int CH       = 4,
    parameter int BITS     = 16,
    parameter int SES_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SES_BITS-1:0]    session_len,
    input  logic [CH-1:0]          inc,
    input  logic [BITS-1:0]        thresh,
    input  logic [$clog2(CH)-1:0]  rd_sel,
    output logic [BITS-1:0]        rd_count,
    output logic [CH-1:0]          sat,
    output logic                   busy,
    output logic                   done,
    output logic                   pass
);

    localparam int SEL_W = $clog2(CH);
    localparam logic [BITS-1:0]     CNT_ONE = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0]     CNT_MAX = {BITS{1'b1}};
    localparam logic [SES_BITS-1:0] REM_ONE = {{(SES_BITS-1){1'b0}}, 1'b1};
    localparam logic [SES_BITS-1:0] REM_ZERO = {SES_BITS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [BITS-1:0]     cnt_r [CH];
    logic [CH-1:0]       sat_r;
    logic [SES_BITS-1:0] rem_r;
    logic                accept_s;
    logic                all_ok_s;
    logic [BITS-1:0]     rd_count_s;

    // Start is only honoured outside a running session.
    assign accept_s = start && (state_r != ST_RUN);

    // Next-state selection; a session ends after the cycle where one cycle remains.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s = (session_len != REM_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (rem_r <= REM_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, session timer, saturating counters and sticky saturation flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sat_r   <= {CH{1'b0}};
            rem_r   <= REM_ZERO;
            for (int i = 0; i < CH; i++) begin
                cnt_r[i] <= {BITS{1'b0}};
            end
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                sat_r <= {CH{1'b0}};
                rem_r <= session_len;
                for (int i = 0; i < CH; i++) begin
                    cnt_r[i] <= {BITS{1'b0}};
                end
            end else if (state_r == ST_RUN) begin
                if (rem_r != REM_ZERO) begin
                    rem_r <= rem_r - REM_ONE;
                end
                for (int i = 0; i < CH; i++) begin
                    if (inc[i]) begin
                        if (cnt_r[i] == CNT_MAX) begin
                            sat_r[i] <= 1'b1;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                end
            end
        end
    end

    // Readout mux; selects beyond the last channel read as zero.
    always_comb begin
        rd_count_s = {BITS{1'b0}};
        for (int i = 0; i < CH; i++) begin
            rd_count_s = (rd_sel == SEL_W'(i)) ? cnt_r[i] : rd_count_s;
        end
    end

    // Pass grading against the live threshold.
    always_comb begin
        all_ok_s = 1'b1;
        for (int i = 0; i < CH; i++) begin
            all_ok_s = all_ok_s & (cnt_r[i] <= thresh);
        end
    end

    assign rd_count = rd_count_s;
    assign sat      = sat_r;
    assign busy     = (state_r == ST_RUN);
    assign done     = (state_r == ST_DONE);
    assign pass     = (state_r == ST_DONE) && all_ok_s;

endmodule

// File: tb/tb_ora_fail_counter_bank.sv
// Self-checking bench: a 4-channel/16-bit and a 3-channel/4-bit bank share stimulus and
// are compared every cycle against a behavioural session model.
module tb_ora_fail_counter_bank;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] session_len;
    logic [3:0]  inc;
    logic [15:0] thresh;
    logic [1:0]  rd_sel;
    logic [15:0] rd_count_a;
    logic [3:0]  sat_a;
    logic        busy_a, done_a, pass_a;
    logic [3:0]  rd_count_b;
    logic [2:0]  sat_b;
    logic        busy_b, done_b, pass_b;

    int n_chk;
    int n_fail;
    int busy_seen;

    // behavioural model: per-instance counts and flags
    int m_cnt [2][4];
    bit m_sat [2][4];
    int m_rem;
    bit m_run;
    bit m_fin;
    int nch  [2] = '{4, 3};
    int maxv [2] = '{65535, 15};

    ora_fail_counter_bank #(.CH(4), .BITS(16), .SES_BITS(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .session_len(session_len),
        .inc(inc), .thresh(thresh), .rd_sel(rd_sel), .rd_count(rd_count_a),
        .sat(sat_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    ora_fail_counter_bank #(.CH(3), .BITS(4), .SES_BITS(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .session_len(session_len),
        .inc(inc[2:0]), .thresh(thresh[3:0]), .rd_sel(rd_sel), .rd_count(rd_count_b),
        .sat(sat_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_cnt[k][i] = 0;
                m_sat[k][i] = 1'b0;
            end
    endtask

    // Applies the session rules for one rising edge using the currently driven inputs.
    task automatic model_step();
        if (rst) begin
            model_clear();
            m_rem = 0;
            m_run = 1'b0;
            m_fin = 1'b0;
        end else if (!m_run && start) begin
            model_clear();
            m_rem = int'(session_len);
            m_run = (session_len != 16'd0);
            m_fin = (session_len == 16'd0);
        end else if (m_run) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < nch[k]; i++)
                    if (inc[i]) begin
                        if (m_cnt[k][i] == maxv[k]) m_sat[k][i] = 1'b1;
                        else m_cnt[k][i] = m_cnt[k][i] + 1;
                    end
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_run = 1'b0;
                m_fin = 1'b1;
            end
        end
    endtask

    function automatic bit model_pass(input int k);
        int th;
        bit ok;
        th = (k == 0) ? int'(thresh) : int'(thresh[3:0]);
        ok = m_fin;
        for (int i = 0; i < nch[k]; i++)
            if (m_cnt[k][i] > th) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [31:0] model_sat(input int k);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nch[k]; i++) v[i] = m_sat[k][i];
        return v;
    endfunction

    task automatic check_all();
        check_val("busy_a", {31'd0, busy_a}, {31'd0, m_run});
        check_val("busy_b", {31'd0, busy_b}, {31'd0, m_run});
        check_val("done_a", {31'd0, done_a}, {31'd0, m_fin});
        check_val("done_b", {31'd0, done_b}, {31'd0, m_fin});
        check_val("pass_a", {31'd0, pass_a}, {31'd0, model_pass(0)});
        check_val("pass_b", {31'd0, pass_b}, {31'd0, model_pass(1)});
        check_val("sat_a", {28'd0, sat_a}, model_sat(0));
        check_val("sat_b", {29'd0, sat_b}, model_sat(1));
        for (int s = 0; s < 4; s++) begin
            rd_sel = s[1:0];
            #1;
            check_val($sformatf("rd_a[%0d]", s), {16'd0, rd_count_a}, 32'(m_cnt[0][s]));
            check_val($sformatf("rd_b[%0d]", s), {28'd0, rd_count_b},
                      (s < 3) ? 32'(m_cnt[1][s]) : 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (busy_a) busy_seen++;
        check_all();
    endtask

    task automatic run_idle(input int n);
        start = 1'b0;
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic begin_session(input int len, input logic [3:0] inc_v);
        start       = 1'b1;
        session_len = len[15:0];
        inc         = inc_v;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; busy_seen = 0;
        m_rem = 0; m_run = 1'b0; m_fin = 1'b0;
        model_clear();
        rst = 1'b1; start = 1'b0; session_len = 16'd0; inc = 4'd0;
        thresh = 16'd0; rd_sel = 2'd0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        run_idle(2);

        // reset mid-session with ch0 at 5
        begin_session(20, 4'b0001);
        inc = 4'b0001;
        run_idle(5);
        rst = 1'b1;
        inc = 4'b1111;
        start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; inc = 4'd0;
        tick();

        // basic session: 8 cycles, channels 0 and 2 active
        busy_seen = 0;
        thresh = 16'd8;
        begin_session(8, 4'b0101);
        inc = 4'b0101;
        run_idle(10);
        check_val("busy_len", busy_seen, 32'd8);
        thresh = 16'd7;
        run_idle(1);
        thresh = 16'd8;
        run_idle(1);

        // saturation on channel 1 of the 4-bit bank (start from DONE)
        thresh = 16'd14;
        begin_session(20, 4'b0010);
        inc = 4'b0010;
        run_idle(22);

        // zero-length session
        busy_seen = 0;
        thresh = 16'd0;
        begin_session(0, 4'b1111);
        inc = 4'b1111;
        run_idle(3);
        check_val("zero_busy", busy_seen, 32'd0);

        // start pulsed while running is ignored
        busy_seen = 0;
        inc = 4'b1000;
        begin_session(6, 4'b1000);
        inc = 4'b1000;
        run_idle(2);
        start = 1'b1; session_len = 16'd2;
        tick();
        start = 1'b0;
        run_idle(5);
        check_val("run_restart_busy", busy_seen, 32'd6);

        // strobes only in the start cycle and the cycle after the last RUN cycle
        thresh = 16'd0;
        begin_session(4, 4'b1111);
        inc = 4'b0000;
        run_idle(3);
        tick();
        inc = 4'b1111;
        tick();
        inc = 4'b0000;
        run_idle(2);

        // randomized sessions
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            start       = ($urandom_range(0, 11) == 0);
            session_len = 16'($urandom_range(0, 20));
            inc         = 4'($urandom);
            thresh      = 16'($urandom_range(0, 12));
            tick();
        end
        rst = 1'b0; start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
